// File: rtl/rst_sequencer.sv
// Staged reset-release controller: holds all domain resets, then releases them
// one at a time in index order, waiting for each domain's ready (or a timeout).
module rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int RDY_TIMEOUT = 200
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_RDY,
  output logic [NUM_DOMAINS-1:0] RST_OUT,
  output logic                   SEQ_DONE,
  output logic                   SEQ_BUSY,
  output logic                   TIMEOUT_ERR,
  output logic [NUM_DOMAINS-1:0] ERR_MASK
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic [1:0]             state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]       idx_r, idx_nxt_s;
  logic [NUM_DOMAINS-1:0] rst_out_r, rst_out_nxt_s;
  logic [NUM_DOMAINS-1:0] err_mask_r, err_mask_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic                   terr_r, terr_nxt_s;
  logic                   rdy_sel_s;

  assign rdy_sel_s = DOMAIN_RDY[idx_r];

  // Next-state and next-output computation; software request overrides everything
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    idx_nxt_s      = idx_r;
    rst_out_nxt_s  = rst_out_r;
    err_mask_nxt_s = err_mask_r;
    done_nxt_s     = done_r;
    busy_nxt_s     = busy_r;
    terr_nxt_s     = terr_r;
    if (SW_RST_REQ) begin
      state_nxt_s    = ST_HOLD;
      cnt_nxt_s      = {CNT_W{1'b0}};
      idx_nxt_s      = {IDX_W{1'b0}};
      rst_out_nxt_s  = {NUM_DOMAINS{1'b0}};
      err_mask_nxt_s = {NUM_DOMAINS{1'b0}};
      done_nxt_s     = 1'b0;
      busy_nxt_s     = 1'b1;
      terr_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = {CNT_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            rst_out_nxt_s[idx_r] = 1'b1;
            state_nxt_s          = ST_WAIT;
            cnt_nxt_s            = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT: begin
          // A timed-out domain is flagged but left released; the sequence moves on
          if (rdy_sel_s || (cnt_r == TO_LAST)) begin
            if (!rdy_sel_s) begin
              err_mask_nxt_s[idx_r] = 1'b1;
              terr_nxt_s            = 1'b1;
            end else begin
              terr_nxt_s = terr_r;
            end
            if (idx_r == IDX_LAST) begin
              state_nxt_s = ST_DONE;
              done_nxt_s  = 1'b1;
              busy_nxt_s  = 1'b0;
            end else begin
              idx_nxt_s   = idx_r + IDX_ONE;
              cnt_nxt_s   = {CNT_W{1'b0}};
              state_nxt_s = ST_GAP;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s    = ST_HOLD;
          cnt_nxt_s      = {CNT_W{1'b0}};
          idx_nxt_s      = {IDX_W{1'b0}};
          rst_out_nxt_s  = {NUM_DOMAINS{1'b0}};
          err_mask_nxt_s = {NUM_DOMAINS{1'b0}};
          done_nxt_s     = 1'b0;
          busy_nxt_s     = 1'b1;
          terr_nxt_s     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_HOLD;
      cnt_r      <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      rst_out_r  <= {NUM_DOMAINS{1'b0}};
      err_mask_r <= {NUM_DOMAINS{1'b0}};
      done_r     <= 1'b0;
      busy_r     <= 1'b1;
      terr_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      rst_out_r  <= rst_out_nxt_s;
      err_mask_r <= err_mask_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
      terr_r     <= terr_nxt_s;
    end
  end

  assign RST_OUT     = rst_out_r;
  assign ERR_MASK    = err_mask_r;
  assign SEQ_DONE    = done_r;
  assign SEQ_BUSY    = busy_r;
  assign TIMEOUT_ERR = terr_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues edge-tagged expected
// outputs, a negedge monitor compares them when the bench edge count matches.
module tb_rst_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW_RST_REQ = 1'b0;
  logic [2:0] DOMAIN_RDY = 3'b111;
  logic [2:0] RST_OUT;
  logic       SEQ_DONE;
  logic       SEQ_BUSY;
  logic       TIMEOUT_ERR;
  logic [2:0] ERR_MASK;

  rst_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .DOMAIN_RDY (DOMAIN_RDY),
    .RST_OUT    (RST_OUT),
    .SEQ_DONE   (SEQ_DONE),
    .SEQ_BUSY   (SEQ_BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .ERR_MASK   (ERR_MASK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_no;
    logic [8:0] val;   // {RST_OUT, SEQ_DONE, SEQ_BUSY, TIMEOUT_ERR, ERR_MASK}
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Edge 1 is the first rising edge with RST high
  always @(posedge CLK or negedge RST) begin
    if (!RST) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  // Monitor: compare every expectation whose edge has been reached
  always @(negedge CLK) begin
    exp_t       ent;
    logic [8:0] got;
    got = {RST_OUT, SEQ_DONE, SEQ_BUSY, TIMEOUT_ERR, ERR_MASK};
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      ent = exp_q.pop_front();
      n_vec++;
      if (ent.edge_no < edge_cnt) begin
        n_err++;
        $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)",
                 ent.name, ent.edge_no, edge_cnt);
      end else if (got !== ent.val) begin
        n_err++;
        $display("FAIL %s @edge %0d: got rst=%b done=%b busy=%b terr=%b mask=%b, want rst=%b done=%b busy=%b terr=%b mask=%b",
                 ent.name, edge_cnt, got[8:6], got[5], got[4], got[3], got[2:0],
                 ent.val[8:6], ent.val[5], ent.val[4], ent.val[3], ent.val[2:0]);
      end
    end
  end

  function automatic void push(int e, logic [2:0] ro, logic d, logic b, logic t,
                               logic [2:0] em, string nm);
    exp_t ent;
    ent.edge_no = e;
    ent.val     = {ro, d, b, t, em};
    ent.name    = nm;
    exp_q.push_back(ent);
  endfunction

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (edge_cnt < n) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_edge: reached edge %0d, want %0d", edge_cnt, n);
    end
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 600) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_empty: %0d expectations pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Async reset between edges; the reset values are checked before any edge
  task automatic do_reset(input logic [2:0] rdy);
    @(posedge CLK);
    #1;
    RST        = 1'b0;
    DOMAIN_RDY = rdy;
    SW_RST_REQ = 1'b0;
    #1;
    push(0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, "reset");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic exp_nominal(input string tag);
    push(19, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, {tag, "_pre0"});
    push(20, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, {tag, "_rel0"});
    push(36, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, {tag, "_pre1"});
    push(37, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, {tag, "_rel1"});
    push(53, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, {tag, "_pre2"});
    push(54, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000, {tag, "_rel2"});
    push(55, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, {tag, "_done"});
  endtask

  initial begin
    int k;
    int l;

    // Power-up, all domains ready
    do_reset(3'b111);
    exp_nominal("pwr");
    wait_empty();

    // Domain 1 never ready: timeout after 200 samples
    do_reset(3'b101);
    push(36,  3'b001, 1'b0, 1'b1, 1'b0, 3'b000, "to_pre1");
    push(37,  3'b011, 1'b0, 1'b1, 1'b0, 3'b000, "to_rel1");
    push(236, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, "to_pre_err");
    push(237, 3'b011, 1'b0, 1'b1, 1'b1, 3'b010, "to_err");
    push(252, 3'b011, 1'b0, 1'b1, 1'b1, 3'b010, "to_pre2");
    push(253, 3'b111, 1'b0, 1'b1, 1'b1, 3'b010, "to_rel2");
    push(254, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, "to_done");
    push(258, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, "to_done_hold");

    // One-cycle software request in DONE
    wait_edge(260);
    k = edge_cnt + 1;
    push(k,      3'b000, 1'b0, 1'b1, 1'b0, 3'b000, "sw_clear");
    push(k + 19, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, "sw_pre0");
    push(k + 20, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, "sw_rel0");
    push(k + 36, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, "sw_pre1");
    push(k + 37, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, "sw_rel1");
    push(k + 40, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, "sw_wait1");
    SW_RST_REQ = 1'b1;
    @(negedge CLK);
    SW_RST_REQ = 1'b0;

    // Software request held 10 edges while waiting on domain 1
    wait_edge(k + 40);
    for (int i = 1; i <= 10; i++)
      push(k + 40 + i, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, "abort_held");
    l = k + 50;
    push(l + 19, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, "abort_pre0");
    push(l + 20, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, "abort_rel0");
    SW_RST_REQ = 1'b1;
    repeat (10) @(negedge CLK);
    SW_RST_REQ = 1'b0;
    wait_empty();

    // Async reset mid-GAP for domain 2, then nominal timing again
    do_reset(3'b111);
    push(20, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, "gap_rel0");
    push(37, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, "gap_rel1");
    push(45, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000, "gap_mid2");
    wait_edge(45);
    do_reset(3'b111);
    exp_nominal("rerun");
    wait_empty();

    // Unselected ready bits must be ignored
    do_reset(3'b111);
    exp_nominal("ign");
    wait_edge(21);
    DOMAIN_RDY = 3'b110;
    while (edge_cnt < 50) begin
      @(negedge CLK);
      DOMAIN_RDY[0] = ~DOMAIN_RDY[0];
    end
    DOMAIN_RDY[0] = 1'b0;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
Staged reset-release controller placed directly after the reset synchronizer. It takes the synchronized active-low system reset and releases NUM_DOMAINS downstream reset lines one at a time, in index order. Each domain must report ready, or time out, before the next domain is released. A software request re-asserts all domain resets and re-runs the sequence.

Parameters:
NUM_DOMAINS, 3, number of sequenced reset outputs (>=2)
CNT_W, 8, width of the shared cycle counter
HOLD_CYCLES, 4, minimum cycles all domain resets stay asserted before sequencing (1..2^CNT_W-1)
GAP_CYCLES, 16, cycles between sequence start or previous domain completion and the next release (1..2^CNT_W-1)
RDY_TIMEOUT, 200, maximum DOMAIN_RDY samples per domain before it is flagged (1..2^CNT_W-1)

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  asynchronous, active-low reset (synchronized deassertion from upstream)
SW_RST_REQ  input  1  software reset request, level, CLK-synchronous
DOMAIN_RDY  input  NUM_DOMAINS  per-domain ready, CLK-synchronous
RST_OUT  output  NUM_DOMAINS  per-domain reset, active-low, registered
SEQ_DONE  output  1  all domains released, registered
SEQ_BUSY  output  1  sequence in progress or hold active, registered
TIMEOUT_ERR  output  1  any domain timed out this sequence, registered
ERR_MASK  output  NUM_DOMAINS  per-domain timeout flags, registered

Behaviour:
- RST low (async): state=HOLD, counter=0, idx=0, RST_OUT=all 0, SEQ_DONE=0, SEQ_BUSY=1, TIMEOUT_ERR=0, ERR_MASK=0.
- Every output is a flop. Nothing combinational reaches a port.
- Edge numbering: edge 1 is the first rising CLK edge with RST high.
- HOLD:
  - RST_OUT=all 0.
  - Counter increments only while SW_RST_REQ=0. SW_RST_REQ=1 clears the counter.
  - On the edge where the counter reaches HOLD_CYCLES-1 with SW_RST_REQ=0: go to GAP, counter=0, idx=0.
- GAP:
  - Count GAP_CYCLES edges.
  - On the last one: RST_OUT[idx]<=1, go to WAIT_RDY, counter=0.
- WAIT_RDY:
  - Sample DOMAIN_RDY[idx] each edge.
  - If DOMAIN_RDY[idx]=1: advance.
  - Else, if this is the RDY_TIMEOUT-th sample: ERR_MASK[idx]<=1, TIMEOUT_ERR<=1, advance. The timed-out domain stays released.
  - Advance: if idx=NUM_DOMAINS-1, go to DONE (SEQ_DONE<=1, SEQ_BUSY<=0). Otherwise idx++, counter=0, go to GAP.
- DONE:
  - Outputs stable.
  - SW_RST_REQ=1 sampled: go to HOLD, with RST_OUT<=0, SEQ_DONE<=0, SEQ_BUSY<=1, ERR_MASK<=0, TIMEOUT_ERR<=0 on the same edge.
- SW_RST_REQ=1 in GAP or WAIT_RDY: abort. Take the same HOLD entry as from DONE.
- SW_RST_REQ takes priority over every other transition.
- Released domains stay released until the next HOLD. Bits of RST_OUT only go 0->1, in increasing index order.
- DOMAIN_RDY bits other than [idx] are ignored, including early-high ready for unreleased domains and toggling ready for already-released domains.
- Counter never wraps: all terminal counts are below 2^CNT_W.

Test Plan:
1. Power-up with DOMAIN_RDY=111 and SW_RST_REQ=0 -> RST_OUT=001 at edge 20, 011 at edge 37, 111 at edge 54. SEQ_DONE=1 and SEQ_BUSY=0 at edge 55. ERR_MASK=000.
2. DOMAIN_RDY=101 (domain 1 never ready) -> RST_OUT=011 at edge 37. ERR_MASK=010 and TIMEOUT_ERR=1 at edge 237. RST_OUT=111 at edge 253. SEQ_DONE=1 at edge 254.
3. In DONE, after test 2, SW_RST_REQ pulsed high for one cycle, sampled at edge k -> at edge k: RST_OUT=000, SEQ_DONE=0, ERR_MASK=000, TIMEOUT_ERR=0. RST_OUT[0]=1 at edge k+20.
4. SW_RST_REQ held high 10 edges while in WAIT_RDY for domain 1 -> RST_OUT=000 on the first sampled edge and stays 000 while held. RST_OUT[0] rises 20 edges after the last sampled-high edge.
5. RST asserted mid-GAP for domain 2 with no clock edge -> immediately RST_OUT=000, SEQ_DONE=0, SEQ_BUSY=1, ERR_MASK=000. After deassertion, test 1 timing repeats exactly.
6. DOMAIN_RDY[2]=1 from edge 1; DOMAIN_RDY[0] drops to 0 after domain 0 advances; DOMAIN_RDY[1]=1 -> no early release of domain 2, domain 0 stays released, timing identical to test 1.
